// File: rtl/fir_pkg.sv
// Shared constants for the FIR MAC datapath: widths, default taps,
// address encodings and frame geometry.
package fir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  // Two extra bits cover the worst-case sum of three full-scale products.
  localparam int ACC_W_DEF  = DATA_W_DEF + COEF_W_DEF + 2;

  localparam int H0_DEF = 1;
  localparam int H1_DEF = 2;
  localparam int H2_DEF = 3;

  localparam int N_TAPS = 3;
  localparam int N_OUT  = 5;

  typedef enum logic [1:0] {
    ADDR_0    = 2'd0,
    ADDR_1    = 2'd1,
    ADDR_2    = 2'd2,
    ADDR_NONE = 2'd3
  } addr_e;

  localparam logic [2:0] IDX_LAST = 3'(N_OUT - 1);

  // Output index advances 0..N_OUT-1 and wraps for the next frame.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply and accumulate stages: registered product with its term flags,
// then the accumulator that emits a finished sum when its last term lands.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = DATA_W + COEF_W + 2
) (
  input  logic                     clk,
  input  logic                     global_reset,
  input  logic signed [DATA_W-1:0] i_r1,
  input  logic signed [COEF_W-1:0] i_r2,
  input  logic                     i_v0,
  input  logic                     i_f0,
  input  logic                     i_load_now,
  output logic signed [ACC_W-1:0]  o_y_out,
  output logic                     o_y_valid,
  output logic [2:0]               o_y_idx
);

  localparam int P_W = DATA_W + COEF_W;

  logic signed [P_W-1:0]   r_p;
  logic                    r_v1;
  logic                    r_f1;
  logic                    r_l1;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_y_out;
  logic                    r_y_valid;
  logic [2:0]              r_y_idx;

  logic signed [ACC_W-1:0] w_p_ext;
  logic signed [ACC_W-1:0] w_acc_next;

  assign w_p_ext    = {{(ACC_W - P_W){r_p[P_W-1]}}, r_p};
  // A first term restarts the sum even if the previous one never closed.
  assign w_acc_next = r_f1 ? w_p_ext : r_acc + w_p_ext;

  // Stage 1: product plus flags; a term is last when no load follows it.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      r_p  <= '0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      r_l1 <= 1'b0;
    end else begin
      r_p  <= P_W'(i_r1) * P_W'(i_r2);
      r_v1 <= i_v0;
      r_f1 <= i_f0;
      r_l1 <= i_v0 & ~i_load_now;
    end
  end

  // Stage 2: accumulate valid terms and publish a closed sum with its index.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_y_idx   <= '0;
    end else begin
      if (r_v1) r_acc <= w_acc_next;
      if (r_v1 && r_l1) begin
        r_y_out   <= w_acc_next;
        r_y_valid <= 1'b1;
        r_y_idx   <= next_idx(r_y_idx);
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  // The index output shows the slot of the sum currently on y_out.
  logic [2:0] r_out_idx;

  // Capture the pre-increment index alongside each published sum.
  always_ff @(posedge clk) begin
    if (global_reset) r_out_idx <= '0;
    else if (r_v1 && r_l1) r_out_idx <= r_y_idx;
  end

  assign o_y_out   = r_y_out;
  assign o_y_valid = r_y_valid;
  assign o_y_idx   = r_out_idx;

endmodule

// File: rtl/fir_mac_datapath.sv
// FIR datapath driven by the sequencing FSM: sample RAM, coefficient ROM,
// operand registers, and the MAC unit producing y0..y4 per frame.
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = DATA_W + COEF_W + 2,
  parameter logic signed [COEF_W-1:0] H0 = COEF_W'(H0_DEF),
  parameter logic signed [COEF_W-1:0] H1 = COEF_W'(H1_DEF),
  parameter logic signed [COEF_W-1:0] H2 = COEF_W'(H2_DEF)
) (
  input  logic                     clk,
  input  logic                     global_reset,
  input  logic                     mac_reset,
  input  logic                     ld1,
  input  logic                     ld2,
  input  logic                     wr,
  input  logic [1:0]               add_ram,
  input  logic [1:0]               add_rom,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [ACC_W-1:0]  y_out,
  output logic                     y_valid,
  output logic [2:0]               y_idx
);

  logic signed [DATA_W-1:0] r_ram [N_TAPS];
  logic signed [DATA_W-1:0] r_r1;
  logic signed [COEF_W-1:0] r_r2;
  logic                     r_v0;
  logic                     r_f0;

  logic signed [DATA_W-1:0] w_ram_rd;
  logic signed [COEF_W-1:0] w_rom_rd;
  logic                     w_load_now;

  assign w_load_now = ld1 & ld2;

  // RAM read is combinational from pre-edge contents; unmapped address reads 0.
  always_comb begin
    w_ram_rd = '0;
    case (addr_e'(add_ram))
      ADDR_0:  w_ram_rd = r_ram[0];
      ADDR_1:  w_ram_rd = r_ram[1];
      ADDR_2:  w_ram_rd = r_ram[2];
      default: w_ram_rd = '0;
    endcase
  end

  // Coefficient ROM; unmapped address reads 0.
  always_comb begin
    w_rom_rd = '0;
    case (addr_e'(add_rom))
      ADDR_0:  w_rom_rd = H0;
      ADDR_1:  w_rom_rd = H1;
      ADDR_2:  w_rom_rd = H2;
      default: w_rom_rd = '0;
    endcase
  end

  // Sample RAM writes; writes to the unmapped address are dropped.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      for (int i = 0; i < N_TAPS; i++) r_ram[i] <= '0;
    end else if (wr && addr_e'(add_ram) != ADDR_NONE) begin
      r_ram[add_ram] <= x_in;
    end
  end

  // Stage 0: operand loads; only a paired load issues a term.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_v0 <= 1'b0;
      r_f0 <= 1'b0;
    end else begin
      if (ld1) r_r1 <= w_ram_rd;
      if (ld2) r_r2 <= w_rom_rd;
      r_v0 <= w_load_now;
      r_f0 <= mac_reset & w_load_now;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk          (clk),
    .global_reset (global_reset),
    .i_r1         (r_r1),
    .i_r2         (r_r2),
    .i_v0         (r_v0),
    .i_f0         (r_f0),
    .i_load_now   (w_load_now),
    .o_y_out      (y_out),
    .o_y_valid    (y_valid),
    .o_y_idx      (y_idx)
  );

endmodule
